bit_count_checker: RTL and testbench

BIT_COUNT_CHECKER -- requirements
Module: bit_count_checker

---
 rtl/bit_count_checker_if.sv | 25 ++
 rtl/bit_count_checker.sv | 128 ++++++++++++
 tb/tb_bit_count_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bit_count_checker_if.sv
// Signal bundle for bit_count_checker: the sampled 4-bit count with its
// qualifier, and the lock / error / wrap status returned by the checker.
interface bit_count_checker_if;
  logic       en;
  logic       r1;
  logic       r2;
  logic       r3;
  logic       r4;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [7:0] err_count;

  // Count source side: drives the sample, observes status.
  modport master (
    output en, r1, r2, r3, r4,
    input  locked, err, wrap, err_count
  );

  // Checker side.
  modport slave (
    input  en, r1, r2, r3, r4,
    output locked, err, wrap, err_count
  );
endinterface

// File: rtl/bit_count_checker.sv
// Watches a free-running 4-bit up-counter and checks that each qualified
// sample is the previous one plus one (mod 16). After LOCK_CNT consecutive
// good increments it declares lock; a bad increment while locked raises a
// one-cycle err pulse, counts it, and drops lock until the sequence recovers.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | out of reset, next qualified sample seeds the reference
// ACQUIRE | counting consecutive good increments toward lock
// LOCKED  | sequence trusted; mismatches are reported as errors
// LOST    | lock dropped after an error, waiting for a good increment
module bit_count_checker #(
  parameter int unsigned LOCK_CNT = 3
) (
  input logic                clk,
  input logic                rst,
  bit_count_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [2:0] LOCK_RUN      = 3'(LOCK_CNT);
  localparam bit         LOCK_ON_FIRST = (LOCK_CNT == 1);

  state_t     state;
  logic [3:0] ref_q;
  logic [2:0] run_q;
  logic       locked_q;
  logic       err_q;
  logic       wrap_q;
  logic [7:0] err_cnt_q;

  logic [3:0] sample;
  logic [3:0] expect_val;
  logic       match;
  logic [2:0] run_inc;

  // Current sample, the value the counter should show next, and the run step.
  assign sample     = {bus.r4, bus.r3, bus.r2, bus.r1};
  assign expect_val = ref_q + 4'd1;
  assign match      = (sample == expect_val);
  assign run_inc    = run_q + 3'd1;

  // Sequence FSM; status outputs are registered alongside the state so they
  // change on the same edge that samples the triggering count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ref_q     <= 4'd0;
      run_q     <= 3'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.en) begin
        // Every qualified sample becomes the new reference, good or bad,
        // so recovery is judged against the latest count seen.
        ref_q <= sample;
        unique case (state)
          IDLE: begin
            run_q    <= 3'd0;
            locked_q <= 1'b0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match) begin
              if (run_inc == LOCK_RUN) begin
                run_q    <= 3'd0;
                locked_q <= 1'b1;
                state    <= LOCKED;
              end else begin
                run_q <= run_inc;
              end
            end else begin
              run_q <= 3'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              // A good increment out of 15 is the natural rollover.
              wrap_q <= (ref_q == 4'hF);
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              state    <= LOST;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
            end
          end
          LOST: begin
            // The recovering increment already counts as the first good one.
            if (match) begin
              if (LOCK_ON_FIRST) begin
                run_q    <= 3'd0;
                locked_q <= 1'b1;
                state    <= LOCKED;
              end else begin
                run_q <= 3'd1;
                state <= ACQUIRE;
              end
            end
          end
          default: begin
            run_q    <= 3'd0;
            locked_q <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.wrap      = wrap_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_bit_count_checker.sv
// Directed bench for bit_count_checker (LOCK_CNT=3): a vector table covers
// acquisition, wrap, error/recovery and en gating; hand-written sequences
// cover LOST persistence, err_count saturation and asynchronous reset.
module tb_bit_count_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bit_count_checker_if bus ();

  bit_count_checker #(.LOCK_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] s;
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;
  int   mcnt   = 0;

  task automatic add(input logic en, input int s, input logic l, input logic e,
                     input logic w, input int c);
    vec_t v;
    v.en     = en;
    v.s      = 4'(s);
    v.locked = l;
    v.err    = e;
    v.wrap   = w;
    v.cnt    = 8'(c);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] s);
    @(negedge clk);
    bus.en = e;
    {bus.r4, bus.r3, bus.r2, bus.r1} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic l, input logic e,
                         input logic w, input logic [7:0] c);
    chk({nm, " locked"}, 8'(bus.locked), 8'(l));
    chk({nm, " err"}, 8'(bus.err), 8'(e));
    chk({nm, " wrap"}, 8'(bus.wrap), 8'(w));
    chk({nm, " err_count"}, bus.err_count, c);
  endtask

  // One forced mismatch out of LOCKED, then three good increments to relock.
  task automatic mm_recover(input string nm);
    cur  = (cur + 5) % 16;
    mcnt = (mcnt < 255) ? mcnt + 1 : 255;
    step(1'b1, 4'(cur));
    chk_all({nm, " mismatch"}, 1'b0, 1'b1, 1'b0, 8'(mcnt));
    for (int k = 0; k < 3; k++) begin
      cur = (cur + 1) % 16;
      step(1'b1, 4'(cur));
    end
    chk({nm, " relock"}, 8'(bus.locked), 8'd1);
    chk({nm, " relock err"}, 8'(bus.err), 8'd0);
  endtask

  initial begin
    // Acquisition 0..4: lock on the sample of 3.
    add(1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0);
    add(1, 3, 1, 0, 0, 0);
    add(1, 4, 1, 0, 0, 0);
    for (int s = 5; s <= 13; s++) add(1, s, 1, 0, 0, 0);
    // Rollover: wrap pulses after the 0 sample only.
    add(1, 14, 1, 0, 0, 0);
    add(1, 15, 1, 0, 0, 0);
    add(1, 0,  1, 0, 1, 0);
    add(1, 1,  1, 0, 0, 0);
    for (int s = 2; s <= 5; s++) add(1, s, 1, 0, 0, 0);
    // Locked at 5, jump to 9: error, then relock after 12.
    add(1, 9,  0, 1, 0, 1);
    add(1, 10, 0, 0, 0, 1);
    add(1, 11, 0, 0, 0, 1);
    add(1, 12, 1, 0, 0, 1);
    // en gating: held sample must not be re-checked while en=0.
    add(1, 13, 1, 0, 0, 1);
    add(0, 13, 1, 0, 0, 1);
    add(0, 13, 1, 0, 0, 1);
    add(1, 14, 1, 0, 0, 1);

    bus.en = 1'b0;
    {bus.r4, bus.r3, bus.r2, bus.r1} = 4'd0;
    #2 rst = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].s);
      chk_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err,
              vecs[i].wrap, vecs[i].cnt);
    end

    // LOST persists through a second mismatch without a second err.
    step(1'b1, 4'd3);
    chk_all("lost enter", 1'b0, 1'b1, 1'b0, 8'd2);
    step(1'b1, 4'd8);
    chk_all("lost again", 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b1, 4'd9);
    chk_all("lost recover", 1'b0, 1'b0, 1'b0, 8'd2);
    step(1'b1, 4'd10);
    step(1'b1, 4'd11);
    chk_all("lost relock", 1'b1, 1'b0, 1'b0, 8'd2);
    cur  = 11;
    mcnt = 2;

    // Saturation: 256 more errors must pin err_count at 255.
    for (int n = 0; n < 256; n++) mm_recover($sformatf("sat%0d", n));
    chk("sat final", bus.err_count, 8'd255);

    // Fresh reset, reacquire, accumulate err_count=4.
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s <= 3; s++) step(1'b1, 4'(s));
    chk("reacq locked", 8'(bus.locked), 8'd1);
    chk("reacq count", bus.err_count, 8'd0);
    cur  = 3;
    mcnt = 0;
    for (int n = 0; n < 4; n++) mm_recover($sformatf("pre%0d", n));
    chk("pre count", bus.err_count, 8'd4);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst = 1'b0;
    #1;
    chk_all("async rst", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 4'd7);
    chk_all("rst held edge", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b0;
    step(1'b1, 4'd0);
    chk_all("post rst 0", 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    chk("post rst 2", 8'(bus.locked), 8'd0);
    step(1'b1, 4'd3);
    chk_all("post rst lock", 1'b1, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
